bram_seq_reader: RTL
====================

# bram_seq_reader

Sequencer that sits directly upstream of the 10-entry, 4-bit synchronous-read lookup BRAM. On a start pulse it drives the BRAM address port from index 0 to DEPTH-1 and absorbs the BRAM's one-cycle read latency. It presents each returned word on a valid/ready output for the display/consumer stage, with an optional looping mode and a per-pass XOR checksum.

## Interface
- DEPTH, 10: number of BRAM entries walked per pass (1..2^ADDR_W).
- ADDR_W, 4: BRAM address width.
- DATA_W, 4: BRAM data width.
- clk  input  1  single clock; all logic on posedge clk.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  single-cycle request to begin a pass from index 0.
- stop  input  1  abort the current operation.
- loop_en  input  1  1 = wrap to index 0 after DEPTH-1 instead of finishing.
- mem_addr  output  ADDR_W  registered address to BRAM.
- mem_data  input  DATA_W  BRAM read data (valid one cycle after mem_addr is sampled).
- out_data  output  DATA_W  captured word.
- out_index  output  ADDR_W  index of out_data.
- out_valid  output  1  out_data/out_index valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready at a clk edge.
- busy  output  1  pass in progress.
- done  output  1  sticky; last pass completed (non-loop).
- checksum  output  DATA_W  XOR of all words of the most recently completed pass.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD, DONE.
- Reset (rst_n=0 at an edge, any state): state IDLE; mem_addr=0, out_data=0, out_index=0, out_valid=0, busy=0, done=0, checksum=0, accumulator=0.
- IDLE/DONE + start: index=0, mem_addr=0, accumulator=0, done=0, busy=1 -> ISSUE.
- ISSUE: BRAM samples mem_addr this edge -> WAIT.
- WAIT: capture mem_data into out_data, out_index=index, out_valid=1 -> HOLD.
- HOLD: out_data, out_index, mem_addr frozen while out_ready=0. On accept: accumulator ^= out_data; out_valid=0.
  - index < DEPTH-1: index+1, mem_addr=index+1 -> ISSUE.
  - index = DEPTH-1 and loop_en=1: checksum = accumulator ^ out_data; accumulator=0; index=0, mem_addr=0 -> ISSUE.
  - index = DEPTH-1 and loop_en=0: checksum updated the same way; busy=0, done=1 -> DONE.
- loop_en is sampled only at the accept of index DEPTH-1.
- start while busy=1: ignored.
- stop (any non-IDLE state): -> IDLE next edge.
  - out_valid=0, busy=0, done=0.
  - checksum keeps the last completed value; accumulator cleared.
- Priority: rst_n > stop > accept/start.
- Index and accumulator arithmetic is modulo width. No index ever exceeds DEPTH-1, so the BRAM out-of-range path is never exercised.

## Timing
- start sampled at edge E0. Then ISSUE after E0 and WAIT after E1. out_valid=1 with word 0 after E2.
- With out_ready held 1, word k is valid after E(3k+2) and accepted at E(3k+3): 3 cycles per word.
- Final accept at E(3·DEPTH). done=1 and the checksum update are visible after that same edge. With DEPTH=10 this is E30.
- Backpressure adds one cycle per cycle of out_ready=0. No word is dropped or duplicated.
- done stays 1 until the next start, stop, or reset.

## Test plan
- Reset: hold rst_n=0 three cycles with start=1 -> all outputs 0 and state IDLE. Then release with start=0 -> outputs stay 0.
- Single pass, out_ready=1, loop_en=0, BRAM contents A,C,F,1,6,8,5,3,E,2 -> accepted out_data A,C,F,1,6,8,5,3,E,2 with out_index 0..9, accepted at E3,E6,…,E30. After E30: done=1, busy=0, checksum=4'hC.
- Backpressure: drop out_ready for 5 cycles while out_index=3 -> out_data holds 4'h1, mem_addr holds 3, no advance. The pass completes 5 cycles later, still with checksum 4'hC.
- Loop: loop_en=1 -> mem_addr wraps 9->0, checksum=4'hC after each pass, done stays 0. Clear loop_en mid-pass -> done=1 at the end of that pass.
- Stop at out_index=4 -> IDLE next edge with out_valid=0, busy=0, done=0, checksum unchanged. A new start then restarts from index 0 and first delivers A.
- Abort and ignore: a start pulse at out_index=6 is ignored. rst_n=0 at out_index=7 -> full reset values next edge.

Source files
------------

// File: rtl/bram_seq_reader_if.sv
// Address/data link to the lookup BRAM plus the valid/ready word stream to the consumer.
interface bram_seq_reader_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr,
    output out_data,
    output out_index,
    output out_valid,
    input  mem_data,
    input  out_ready
  );

  modport slave (
    input  mem_addr,
    input  out_data,
    input  out_index,
    input  out_valid,
    output mem_data,
    output out_ready
  );
endinterface

// File: rtl/bram_seq_reader.sv
// Walks a synchronous-read BRAM from 0 to DEPTH-1, hides its one-cycle latency and streams
// each word out on valid/ready, with optional wrap-around and a per-pass XOR checksum.
module bram_seq_reader #(
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  bram_seq_reader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              accept;

  assign accept = out_valid_q && bus.out_ready;

  // Next-state and register updates; stop overrides everything except reset.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    mem_addr_d  = mem_addr_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    checksum_d  = checksum_q;
    acc_d       = acc_q;

    if (stop && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      acc_d       = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            index_d    = '0;
            mem_addr_d = '0;
            acc_d      = '0;
            done_d     = 1'b0;
            busy_d     = 1'b1;
            state_d    = S_ISSUE;
          end
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          out_data_d  = bus.mem_data;
          out_index_d = index_q;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
        S_HOLD: begin
          if (accept) begin
            out_valid_d = 1'b0;
            if (index_q < LAST_IDX) begin
              acc_d      = acc_q ^ out_data_q;
              index_d    = index_q + ADDR_W'(1);
              mem_addr_d = index_q + ADDR_W'(1);
              state_d    = S_ISSUE;
            end else begin
              // End of pass: publish the checksum and restart the accumulator.
              checksum_d = acc_q ^ out_data_q;
              acc_d      = '0;
              index_d    = '0;
              mem_addr_d = '0;
              if (loop_en) begin
                state_d = S_ISSUE;
              end else begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      mem_addr_q  <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      mem_addr_q  <= mem_addr_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign checksum      = checksum_q;
endmodule
